// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sharing of one adder_sub (alu_*) among NUM_REQ requesters (req_*), results returned tagged on resp_*
module addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  parameter int TIMEOUT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]     req_a,
  input  logic [NUM_REQ*WIDTH-1:0]     req_b,
  input  logic [NUM_REQ-1:0]           req_op,
  input  logic [NUM_REQ-1:0]           req_cin,
  output logic [WIDTH-1:0]             alu_a,
  output logic [WIDTH-1:0]             alu_b,
  output logic                         alu_add_en,
  output logic                         alu_sub_en,
  output logic                         alu_carry_in,
  input  logic [WIDTH-1:0]             alu_data_out,
  input  logic                         alu_carry_out,
  input  logic                         alu_out_en,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id,
  output logic [WIDTH-1:0]             resp_data,
  output logic                         resp_carry,
  output logic                         resp_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);
  localparam logic [3:0] TM1 = 4'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_n;
  logic [IW-1:0] rr_ptr, id_r, off, gnt_id;
  logic [IW:0] sum;
  logic [NUM_REQ-1:0] rot;
  logic [WIDTH-1:0] a_r, b_r, data_r;
  logic op_r, cin_r, carry_r, err_r, gnt_any, acc, fire, done;
  logic [3:0] cnt;
  assign rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
  always_comb begin
    gnt_any = 1'b0;
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (rot[IW'(i)]) begin
        gnt_any = 1'b1;
        off = IW'(i);
      end
  end
  assign sum = {1'b0, rr_ptr} + {1'b0, off};
  assign gnt_id = sum >= NR ? IW'(sum - NR) : IW'(sum);
  assign acc = state == IDLE && gnt_any;
  assign fire = state == ISSUE && (alu_out_en || cnt == TM1);
  assign done = state == RESP && resp_ready;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb state_n = acc ? ISSUE : fire ? RESP : done ? IDLE : state;
  always_ff @(posedge clk)
    if (rst) begin
      rr_ptr <= '0;
      id_r <= '0;
      a_r <= '0;
      b_r <= '0;
      op_r <= 1'b0;
      cin_r <= 1'b0;
      cnt <= '0;
      data_r <= '0;
      carry_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      if (acc) begin
        a_r <= req_a[gnt_id*WIDTH +: WIDTH];
        b_r <= req_b[gnt_id*WIDTH +: WIDTH];
        op_r <= req_op[gnt_id];
        cin_r <= req_cin[gnt_id];
        id_r <= gnt_id;
        cnt <= '0;
      end
      if (state == ISSUE) cnt <= cnt + 1'b1;
      if (fire) begin
        data_r <= alu_out_en ? alu_data_out : '0;
        carry_r <= alu_out_en & alu_carry_out;
        err_r <= ~alu_out_en;
      end
      if (done) rr_ptr <= id_r == LAST ? '0 : id_r + 1'b1;
    end
  assign req_ready = acc && !rst ? NUM_REQ'(1) << gnt_id : '0;
  assign alu_add_en = state == ISSUE && !op_r && !rst;
  assign alu_sub_en = state == ISSUE && op_r && !rst;
  assign alu_a = a_r;
  assign alu_b = b_r;
  assign alu_carry_in = cin_r;
  assign resp_valid = state == RESP && !rst;
  assign resp_id = id_r;
  assign resp_data = data_r;
  assign resp_carry = carry_r;
  assign resp_err = err_r;
endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one adder_sub datapath instance between NUM_REQ independent requesters.
- Round-robin arbitration across requesters; one operation in flight at a time.
- Drives the adder_sub operand and enable pins, captures {carry_out, data_out} when out_en is high, and returns the result to the winning requester tagged with its index.
- Sits between client blocks and the adder_sub instance; adder_sub is combinational from operands/enables to outputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); ID width = clog2(NUM_REQ).
- WIDTH, 8, operand/result width; matches adder_sub.
- TIMEOUT, 4, max consecutive ISSUE cycles waiting for alu_out_en before error response (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept strobe; at most one bit high.
- req_a  in  NUM_REQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand B, same packing as req_a.
- req_op  in  NUM_REQ  0 = add, 1 = subtract.
- req_cin  in  NUM_REQ  carry_in per requester.
- alu_a  out  WIDTH  to adder_sub A.
- alu_b  out  WIDTH  to adder_sub B.
- alu_add_en  out  1  to adder_sub add_en.
- alu_sub_en  out  1  to adder_sub sub_en.
- alu_carry_in  out  1  to adder_sub carry_in.
- alu_data_out  in  WIDTH  from adder_sub data_out.
- alu_carry_out  in  1  from adder_sub carry_out.
- alu_out_en  in  1  from adder_sub out_en; result valid when high.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  clog2(NUM_REQ)  index of the requester being answered.
- resp_data  out  WIDTH  captured data_out.
- resp_carry  out  1  captured carry_out.
- resp_err  out  1  1 = timeout, no valid result.

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - state = IDLE; rr_ptr = 0; operand registers and timeout counter = 0.
  - All outputs 0: req_ready, alu_*, resp_*.
  - Reset mid-operation abandons the transaction; no response is issued.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Grant the first i with req_valid[i] = 1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[grant] = 1 combinationally in the same cycle. The handshake completes at that clock edge.
  - At that edge, latch req_a/req_b/req_op/req_cin of the grant and the grant id, clear the timeout counter, and go to ISSUE.
  - No req_valid: stay in IDLE with req_ready = 0.
- ISSUE:
  - alu_a/alu_b/alu_carry_in driven from the latched registers.
  - alu_add_en = ~op and alu_sub_en = op; exactly one of them is high.
  - alu_out_en = 1: capture resp_data = alu_data_out, resp_carry = alu_carry_out, resp_err = 0; go to RESP.
  - alu_out_en = 0: increment the counter. If the counter reaches TIMEOUT, go to RESP with resp_err = 1, resp_data = 0, resp_carry = 0.
- RESP:
  - resp_valid = 1; resp_id/resp_data/resp_carry/resp_err are held stable until resp_ready = 1 at an edge.
  - On that edge: rr_ptr = (id + 1) mod NUM_REQ, then go to IDLE.
- Outside ISSUE:
  - alu_add_en = alu_sub_en = 0.
  - alu_a/alu_b/alu_carry_in hold their last values (no needless toggling).
- Latency: accept edge E → ISSUE cycle → resp_valid high in the cycle after E+1, i.e. 2 cycles minimum. Peak throughput is one operation per 3 cycles (IDLE, ISSUE, RESP).
- Arithmetic: the arbiter does no arithmetic; results are passed bit-exact from adder_sub.
- Requester rules:
  - Hold req_valid and operands stable until req_ready is seen.
  - Dropping req_valid before the grant is legal; that requester is simply not served.
  - A requester may re-request in the same cycle its response is consumed. It is then arbitrated normally from the updated rr_ptr.
- Simultaneous requests: exactly one grant per IDLE cycle. Requesters not granted see req_ready = 0 and keep waiting.
- Fairness: with all NUM_REQ requesting continuously, grants cycle 0, 1, 2, 3, 0, ... and no requester waits more than NUM_REQ−1 operations.
- rr_ptr wraps from NUM_REQ−1 to 0.
- Timeouts also advance rr_ptr.

Test Plan:
- Reset behaviour: assert rst 2 cycles with req_valid = 4'b1111 → all outputs 0 during reset. First grant after release goes to requester 0.
- Single add: req 2 with A = 0xFF, B = 0x01, op = 0, cin = 0; alu_out_en = 1 → alu_add_en = 1 for one cycle; resp_valid 2 cycles after accept with id = 2, data = 0x00, carry = 1, err = 0.
- Round-robin fairness: all four requesters request continuously, resp_ready tied high → grant order 0, 1, 2, 3, 0, 1; each operation 3 cycles apart; req_ready is never multi-hot.
- Backpressure: resp_ready held low 5 cycles → resp_* stable for all 5 cycles. No new req_ready until resp_ready is seen at an edge.
- Timeout: alu_out_en forced 0, TIMEOUT = 4 → exactly 4 ISSUE cycles, then resp_err = 1, data = 0, carry = 0. Next grant goes to (id + 1).
- Reset mid-op: rst asserted during ISSUE → no resp_valid, state IDLE, rr_ptr = 0. The next request completes normally.
